sync_width_conv_fifo: RTL and testbench

Single-clock FIFO with independent, parametrised write and read data widths at an integer power-of-2 ratio, in either direction (upsize 16->32 or downsize 32->16). It is the synchronous successor to the fixed 16-in/32-out FIFO core. It adds bidirectional width conversion, programmable almost thresholds in native units, and defined overflow/underflow handling. It sits between the HSST lane datapath and the packet logic, where both sides share one clock.

---
 rtl/sync_width_conv_fifo.sv | 176 +++++++++++++++++
 tb/tb_sync_width_conv_fifo.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/sync_width_conv_fifo.sv
// Single-clock FIFO with power-of-2 write/read width conversion (upsize or downsize).
// Define SWC_FIFO_ERR_FLAG_EN to add sticky wr_overflow / rd_underflow flags.
module sync_width_conv_fifo #(
  parameter int unsigned WR_DATA_WIDTH    = 16,
  parameter int unsigned RD_DATA_WIDTH    = 32,
  parameter int unsigned WR_DEPTH_WIDTH   = 12,
  parameter int unsigned ALMOST_FULL_NUM  = 1020,
  parameter int unsigned ALMOST_EMPTY_NUM = 4,
  parameter int unsigned OUTPUT_REG       = 0,
  localparam int unsigned W_MIN = (WR_DATA_WIDTH < RD_DATA_WIDTH) ? WR_DATA_WIDTH : RD_DATA_WIDTH,
  localparam int unsigned W_MAX = (WR_DATA_WIDTH < RD_DATA_WIDTH) ? RD_DATA_WIDTH : WR_DATA_WIDTH,
  localparam int unsigned LOG2R = $clog2(W_MAX / W_MIN),
  localparam int unsigned RD_DEPTH_WIDTH = (WR_DATA_WIDTH < RD_DATA_WIDTH) ?
                                           WR_DEPTH_WIDTH - LOG2R : WR_DEPTH_WIDTH + LOG2R
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WR_DATA_WIDTH-1:0]  wr_data,
  input  logic                      wr_en,
  output logic                      wr_full,
  output logic [WR_DEPTH_WIDTH:0]   wr_water_level,
  output logic                      almost_full,
  output logic [RD_DATA_WIDTH-1:0]  rd_data,
  input  logic                      rd_en,
  output logic                      rd_empty,
  output logic [RD_DEPTH_WIDTH:0]   rd_water_level,
  output logic                      almost_empty
`ifdef SWC_FIFO_ERR_FLAG_EN
  ,
  output logic                      wr_overflow,
  output logic                      rd_underflow
`endif
);

  localparam bit          IS_UP   = (WR_DATA_WIDTH < RD_DATA_WIDTH);
  localparam bit          IS_DOWN = (RD_DATA_WIDTH < WR_DATA_WIDTH);
  // Pointers count narrow units; the low LOG2R bits select a lane within a wide row.
  localparam int unsigned UNIT_AW = IS_UP ? WR_DEPTH_WIDTH : WR_DEPTH_WIDTH + LOG2R;
  localparam int unsigned ROW_AW  = UNIT_AW - LOG2R;
  localparam int unsigned LANES   = 1 << LOG2R;
  localparam int unsigned WR_UNITS = WR_DATA_WIDTH / W_MIN;
  localparam int unsigned RD_UNITS = RD_DATA_WIDTH / W_MIN;
  localparam logic [UNIT_AW:0] WR_STEP  = (UNIT_AW+1)'(WR_UNITS);
  localparam logic [UNIT_AW:0] RD_STEP  = (UNIT_AW+1)'(RD_UNITS);
  localparam logic [UNIT_AW:0] FULL_THR = (UNIT_AW+1)'((1 << UNIT_AW) - WR_UNITS);

  logic [LANES-1:0][W_MIN-1:0] mem_q [0:(1 << ROW_AW)-1];

  logic [UNIT_AW:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_s;
  logic                     wr_full_q, wr_full_d, rd_empty_q, rd_empty_d;
  logic                     almost_full_q, almost_full_d, almost_empty_q, almost_empty_d;
  logic [WR_DEPTH_WIDTH:0]  wr_level_q, wr_level_d;
  logic [RD_DEPTH_WIDTH:0]  rd_level_q, rd_level_d;
  logic [RD_DATA_WIDTH-1:0] rd_data_q, rd_data_d, rd_word_s;
  logic [ROW_AW-1:0]        wr_row_s, rd_row_s;
  logic                     wr_acc_s, rd_acc_s;

  assign wr_acc_s = wr_en & ~wr_full_q;
  assign rd_acc_s = rd_en & ~rd_empty_q;
  assign wr_row_s = wr_ptr_q[UNIT_AW-1:LOG2R];
  assign rd_row_s = rd_ptr_q[UNIT_AW-1:LOG2R];

  if (IS_UP) begin : g_wr_lane
    // Narrow writes fill one lane of a wide row, first word in the LSB lane.
    always_ff @(posedge clk) begin
      if (wr_acc_s) mem_q[wr_row_s][wr_ptr_q[LOG2R-1:0]] <= wr_data;
    end
  end else begin : g_wr_row
    // Write word occupies a whole row.
    always_ff @(posedge clk) begin
      if (wr_acc_s) mem_q[wr_row_s] <= wr_data;
    end
  end

  if (IS_DOWN) begin : g_rd_lane
    assign rd_word_s = mem_q[rd_row_s][rd_ptr_q[LOG2R-1:0]];
  end else begin : g_rd_row
    assign rd_word_s = mem_q[rd_row_s];
  end

  // Next pointers, occupancy-derived flags/levels and read data.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    rd_data_d = rd_data_q;
    if (wr_acc_s) begin
      wr_ptr_d = wr_ptr_q + WR_STEP;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (rd_acc_s) begin
      rd_ptr_d  = rd_ptr_q + RD_STEP;
      rd_data_d = rd_word_s;
    end else begin
      rd_ptr_d  = rd_ptr_q;
      rd_data_d = rd_data_q;
    end
    // Flags are registered from next pointers so they track the pointers with no lag.
    count_s        = wr_ptr_d - rd_ptr_d;
    wr_full_d      = (count_s > FULL_THR);
    rd_empty_d     = (count_s < RD_STEP);
    wr_level_d     = count_s[UNIT_AW -: WR_DEPTH_WIDTH+1];
    rd_level_d     = count_s[UNIT_AW -: RD_DEPTH_WIDTH+1];
    almost_full_d  = (32'(wr_level_d) >= ALMOST_FULL_NUM);
    almost_empty_d = (32'(rd_level_d) <= ALMOST_EMPTY_NUM);
  end

  // Pointer, flag and read-data registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q       <= {(UNIT_AW+1){1'b0}};
      rd_ptr_q       <= {(UNIT_AW+1){1'b0}};
      wr_full_q      <= 1'b0;
      rd_empty_q     <= 1'b1;
      wr_level_q     <= {(WR_DEPTH_WIDTH+1){1'b0}};
      rd_level_q     <= {(RD_DEPTH_WIDTH+1){1'b0}};
      almost_full_q  <= (ALMOST_FULL_NUM == 32'd0);
      almost_empty_q <= 1'b1;
      rd_data_q      <= {RD_DATA_WIDTH{1'b0}};
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      wr_full_q      <= wr_full_d;
      rd_empty_q     <= rd_empty_d;
      wr_level_q     <= wr_level_d;
      rd_level_q     <= rd_level_d;
      almost_full_q  <= almost_full_d;
      almost_empty_q <= almost_empty_d;
      rd_data_q      <= rd_data_d;
    end
  end

  if (OUTPUT_REG != 0) begin : g_out_reg
    logic [RD_DATA_WIDTH-1:0] rd_data_pipe_q;
    // Extra output stage; follows rd_data_q so it also holds when reads stop.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) rd_data_pipe_q <= {RD_DATA_WIDTH{1'b0}};
      else     rd_data_pipe_q <= rd_data_q;
    end
    assign rd_data = rd_data_pipe_q;
  end else begin : g_out_direct
    assign rd_data = rd_data_q;
  end

  assign wr_full        = wr_full_q;
  assign rd_empty       = rd_empty_q;
  assign wr_water_level = wr_level_q;
  assign rd_water_level = rd_level_q;
  assign almost_full    = almost_full_q;
  assign almost_empty   = almost_empty_q;

`ifdef SWC_FIFO_ERR_FLAG_EN
  logic wr_overflow_q, wr_overflow_d, rd_underflow_q, rd_underflow_d;

  // Sticky error flags, cleared only by reset.
  always_comb begin
    wr_overflow_d  = wr_overflow_q | (wr_en & wr_full_q);
    rd_underflow_d = rd_underflow_q | (rd_en & rd_empty_q);
  end

  // Error flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_overflow_q  <= 1'b0;
      rd_underflow_q <= 1'b0;
    end else begin
      wr_overflow_q  <= wr_overflow_d;
      rd_underflow_q <= rd_underflow_d;
    end
  end

  assign wr_overflow  = wr_overflow_q;
  assign rd_underflow = rd_underflow_q;
`endif

endmodule

// File: tb/tb_sync_width_conv_fifo.sv
// Directed bench for sync_width_conv_fifo: 16->32, 32->16 and 16->32 with output register.
module tb_sync_width_conv_fifo;
  logic clk, rst;
  logic [15:0] wr_data;
  logic        wr_en, rd_en;
  logic [31:0] dn_wr_data;
  logic        dn_wr_en, dn_rd_en;

  logic        wr_full, almost_full, rd_empty, almost_empty;
  logic [12:0] wr_water_level;
  logic [11:0] rd_water_level;
  logic [31:0] rd_data;

  logic        r_wr_full, r_almost_full, r_rd_empty, r_almost_empty;
  logic [12:0] r_wr_water_level;
  logic [11:0] r_rd_water_level;
  logic [31:0] r_rd_data;

  logic        d_wr_full, d_almost_full, d_rd_empty, d_almost_empty;
  logic [12:0] d_wr_water_level;
  logic [13:0] d_rd_water_level;
  logic [15:0] d_rd_data;
`ifdef SWC_FIFO_ERR_FLAG_EN
  logic u_ovf, u_unf, r_ovf, r_unf, d_ovf, d_unf;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] cnt, lo, hi;
  logic [15:0] exp_q[$];

  sync_width_conv_fifo #(.WR_DATA_WIDTH(16), .RD_DATA_WIDTH(32), .OUTPUT_REG(0)) u_up (
    .clk(clk), .rst(rst), .wr_data(wr_data), .wr_en(wr_en), .wr_full(wr_full),
    .wr_water_level(wr_water_level), .almost_full(almost_full), .rd_data(rd_data),
    .rd_en(rd_en), .rd_empty(rd_empty), .rd_water_level(rd_water_level),
    .almost_empty(almost_empty)
`ifdef SWC_FIFO_ERR_FLAG_EN
    , .wr_overflow(u_ovf), .rd_underflow(u_unf)
`endif
  );

  sync_width_conv_fifo #(.WR_DATA_WIDTH(16), .RD_DATA_WIDTH(32), .OUTPUT_REG(1)) u_reg (
    .clk(clk), .rst(rst), .wr_data(wr_data), .wr_en(wr_en), .wr_full(r_wr_full),
    .wr_water_level(r_wr_water_level), .almost_full(r_almost_full), .rd_data(r_rd_data),
    .rd_en(rd_en), .rd_empty(r_rd_empty), .rd_water_level(r_rd_water_level),
    .almost_empty(r_almost_empty)
`ifdef SWC_FIFO_ERR_FLAG_EN
    , .wr_overflow(r_ovf), .rd_underflow(r_unf)
`endif
  );

  sync_width_conv_fifo #(.WR_DATA_WIDTH(32), .RD_DATA_WIDTH(16), .OUTPUT_REG(0)) u_dn (
    .clk(clk), .rst(rst), .wr_data(dn_wr_data), .wr_en(dn_wr_en), .wr_full(d_wr_full),
    .wr_water_level(d_wr_water_level), .almost_full(d_almost_full), .rd_data(d_rd_data),
    .rd_en(dn_rd_en), .rd_empty(d_rd_empty), .rd_water_level(d_rd_water_level),
    .almost_empty(d_almost_empty)
`ifdef SWC_FIFO_ERR_FLAG_EN
    , .wr_overflow(d_ovf), .rd_underflow(d_unf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_data = 16'h0;
    dn_wr_en = 1'b0; dn_rd_en = 1'b0; dn_wr_data = 32'h0;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_empty", 64'(rd_empty), 64'd1);
    chk("rst_full", 64'(wr_full), 64'd0);
    chk("rst_wlvl", 64'(wr_water_level), 64'd0);
    chk("rst_rlvl", 64'(rd_water_level), 64'd0);
    chk("rst_aempty", 64'(almost_empty), 64'd1);
    chk("rst_afull", 64'(almost_full), 64'd0);
    chk("rst_rdata", 64'(rd_data), 64'd0);
    chk("rst_dn_empty", 64'(d_rd_empty), 64'd1);

    // Scenario 1 / 5: two writes form one read word
    wr_en = 1'b1; wr_data = 16'hFFFF;
    tick();
    chk("s1_empty_half", 64'(rd_empty), 64'd1);
    chk("s1_rlvl_half", 64'(rd_water_level), 64'd0);
    chk("s1_wlvl_half", 64'(wr_water_level), 64'd1);
    wr_data = 16'hFFFE;
    tick();
    wr_en = 1'b0;
    chk("s1_empty_full_word", 64'(rd_empty), 64'd0);
    chk("s1_rlvl", 64'(rd_water_level), 64'd1);
    chk("s1_wlvl", 64'(wr_water_level), 64'd2);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("s1_rdata", 64'(rd_data), 64'hFFFEFFFF);
    chk("s1_empty_after", 64'(rd_empty), 64'd1);
    chk("s5_rdata_lat1", 64'(r_rd_data), 64'd0);
    tick();
    chk("s5_rdata_lat2", 64'(r_rd_data), 64'hFFFEFFFF);
    chk("s1_rdata_hold", 64'(rd_data), 64'hFFFEFFFF);

    // Scenario 2: fill past capacity, then drain
    wr_en = 1'b1;
    for (int i = 0; i < 4097; i++) begin
      wr_data = 16'(i);
      tick();
      if (i == 1018) chk("s2_afull_below", 64'(almost_full), 64'd0);
      if (i == 1019) chk("s2_afull_at", 64'(almost_full), 64'd1);
      if (i == 4094) chk("s2_full_before", 64'(wr_full), 64'd0);
      if (i == 4095) chk("s2_full_at", 64'(wr_full), 64'd1);
    end
    wr_en = 1'b0;
    chk("s2_full_hold", 64'(wr_full), 64'd1);
    chk("s2_wlvl_sat", 64'(wr_water_level), 64'd4096);
    chk("s2_rlvl_full", 64'(rd_water_level), 64'd2048);
    chk("s2_aempty_full", 64'(almost_empty), 64'd0);
`ifdef SWC_FIFO_ERR_FLAG_EN
    chk("s2_overflow", 64'(u_ovf), 64'd1);
`endif
    rd_en = 1'b1;
    for (int k = 0; k < 2048; k++) begin
      tick();
      chk("s2_rdata", 64'(rd_data), 64'({16'(2*k+1), 16'(2*k)}));
    end
    rd_en = 1'b0;
    chk("s2_empty_end", 64'(rd_empty), 64'd1);
    chk("s2_wlvl_end", 64'(wr_water_level), 64'd0);
    chk("s2_full_end", 64'(wr_full), 64'd0);

    // Scenario 3: downsize, LSB half first, read on empty ignored
    dn_wr_en = 1'b1; dn_wr_data = 32'h12345678;
    tick();
    dn_wr_en = 1'b0;
    chk("s3_rlvl", 64'(d_rd_water_level), 64'd2);
    chk("s3_wlvl", 64'(d_wr_water_level), 64'd1);
    dn_rd_en = 1'b1;
    tick();
    chk("s3_rd0", 64'(d_rd_data), 64'h5678);
    tick();
    chk("s3_rd1", 64'(d_rd_data), 64'h1234);
    chk("s3_empty", 64'(d_rd_empty), 64'd1);
    tick();
    dn_rd_en = 1'b0;
    chk("s3_hold", 64'(d_rd_data), 64'h1234);
    chk("s3_rlvl_end", 64'(d_rd_water_level), 64'd0);
`ifdef SWC_FIFO_ERR_FLAG_EN
    chk("s3_underflow", 64'(d_unf), 64'd1);
    chk("s3_no_overflow", 64'(d_ovf), 64'd0);
`endif

    // Scenario 4: steady traffic around level 10
    cnt = 16'hFFFF;
    wr_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wr_data = cnt;
      tick();
      exp_q.push_back(cnt);
      cnt = cnt - 16'd1;
    end
    chk("s4_wlvl_start", 64'(wr_water_level), 64'd10);
    for (int c = 0; c < 100; c++) begin
      wr_data = cnt;
      rd_en = (c % 2 == 1);
      tick();
      exp_q.push_back(cnt);
      cnt = cnt - 16'd1;
      if (c % 2 == 1) begin
        lo = exp_q.pop_front();
        hi = exp_q.pop_front();
        chk("s4_rdata", 64'(rd_data), 64'({hi, lo}));
        chk("s4_wlvl", 64'(wr_water_level), 64'd10);
        chk("s4_rlvl", 64'(rd_water_level), 64'd5);
      end
    end
    rd_en = 1'b0;

    // Scenario 6: asynchronous reset with 100 words stored
    for (int i = 0; i < 90; i++) begin
      wr_data = cnt;
      tick();
      cnt = cnt - 16'd1;
    end
    wr_en = 1'b0;
    chk("s6_wlvl_pre", 64'(wr_water_level), 64'd100);
    rst = 1'b1;
    #2;
    chk("s6_empty", 64'(rd_empty), 64'd1);
    chk("s6_wlvl", 64'(wr_water_level), 64'd0);
    chk("s6_rlvl", 64'(rd_water_level), 64'd0);
    chk("s6_rdata", 64'(rd_data), 64'd0);
    chk("s6_rdata_reg", 64'(r_rd_data), 64'd0);
`ifdef SWC_FIFO_ERR_FLAG_EN
    chk("s6_ovf_clr", 64'(u_ovf), 64'd0);
    chk("s6_unf_clr", 64'(d_unf), 64'd0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    wr_en = 1'b1; wr_data = 16'hAAAA;
    tick();
    wr_data = 16'h5555;
    tick();
    wr_en = 1'b0; rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("s6_rdata_after", 64'(rd_data), 64'h5555AAAA);
    chk("s6_empty_after", 64'(rd_empty), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
